fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the TPI RISC-V core. It drives the word address of the combinational instruction memory (IM) and holds the program counter. It presents each fetched instruction with its PC to decode through a valid/ready handshake. It also applies branch/jump redirects from execute and stops cleanly when the PC leaves the program image.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: byte address of the first fetch after reset
- ROM_DEPTH, 32: number of 32-bit words in IM; word index ≥ ROM_DEPTH is out of image

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; begins fetching from IDLE
- im_addr  out  16  IM word index, always pc[17:2] (combinational from pc register)
- im_instr  in  32  IM read data, combinational from im_addr
- if_valid  out  1  fetch register holds an instruction
- if_instr  out  32  fetched instruction
- if_pc  out  32  byte address of if_instr
- id_ready  in  1  decode accepts if_instr this cycle
- redir_valid  in  1  execute requests a PC redirect (taken branch/jump)
- redir_pc  in  32  redirect target, byte address
- busy  out  1  state is RUN
- done  out  1  state is DONE and fetch register is empty
- err_misaligned  out  1  sticky; a redirect target had redir_pc[1:0] ≠ 0
- instr_count  out  16  count of accepted handshakes, saturating at 16'hFFFF

## Operation
- States: IDLE, RUN, DONE, ERROR.
- IDLE → RUN when start = 1. No fetch occurs in IDLE.
- Advance condition: adv = !if_valid || id_ready.
- RUN, no redirect, adv:
  - If word index pc[31:2] < ROM_DEPTH: if_instr ← im_instr, if_pc ← pc, if_valid ← 1, pc ← pc + 4.
  - Otherwise: if_valid ← 0, pc unchanged, state → DONE.
- RUN, no redirect, !adv: all fetch registers and pc hold. Data stays stable while if_valid && !id_ready.
- Redirect has priority over advance and is honoured regardless of id_ready:
  - Aligned target: if_valid ← 0 (flush), pc ← redir_pc. From RUN or DONE, state → RUN.
  - Misaligned target: if_valid ← 0, err_misaligned ← 1, state → ERROR. pc is not loaded.
  - Redirect in IDLE or ERROR is ignored.
- DONE: no fetch. done = 1 once if_valid = 0. An aligned redirect restarts the sequencer, which covers a backward loop jump resolved after the image end.
- ERROR: sticky until rst_n. if_valid = 0 and no fetch.
- instr_count increments on every cycle with if_valid && id_ready. A handshake in the same cycle as a redirect still counts, because the instruction was consumed before the flush.
- pc arithmetic is modulo 2^32. Only pc[31:2] is compared against ROM_DEPTH.

## Timing
- Reset values (asynchronous): state IDLE, pc RESET_PC, if_valid 0, if_instr 0, if_pc 0, instr_count 0, err_misaligned 0, busy 0, done 0. im_addr = RESET_PC[17:2].
- start sampled high at edge N: RUN after N. First instruction is valid after edge N+1.
- Throughput: one instruction per cycle while id_ready = 1.
- Redirect sampled at edge E: if_valid low for cycle E..E+1. The target instruction is valid after edge E+1, giving exactly one bubble.
- busy, done and err_misaligned are registered-state decodes with no combinational path from inputs.
- im_addr depends only on the pc register. IM is combinational, so no extra wait state is needed.
- rst_n asserted mid-operation clears everything immediately; the in-flight instruction is lost.

## Structure
- Shared package tpi_pkg holds:
  - the state enum fetch_state_t {IDLE, RUN, DONE, ERROR}
  - NOP_INSTR = 32'h0000_0013
  - the default RESET_PC
- Single module, no sub-modules. IM is instantiated beside fetch_ctrl at core level, not inside it.

## Test plan
- Reset/start: release rst_n, start = 1, id_ready = 1 with the current image → if_pc 0, 4, 8 on consecutive cycles; if_instr 0x00000293, 0x00000393, 0x00100313; instr_count = 3.
- Backpressure: id_ready = 0 for 3 cycles while if_pc = 0x10 → if_instr 0x0005ae03 and if_pc held stable, pc unchanged, instr_count frozen; fetch resumes at 0x14 after id_ready = 1.
- Redirect: redir_valid with redir_pc = 0x20 while id_ready = 0 → one bubble (if_valid 0), then if_pc 0x20, if_instr 0x01c00fb3.
- End of image: ROM_DEPTH = 28, run straight from 0x60 with no redirects → last if_pc 0x6C; then if_valid 0 and done = 1. A later redir_pc = 0x20 returns to RUN and fetches 0x20.
- Misaligned: redir_pc = 0x22 → err_misaligned = 1, state ERROR, if_valid stays 0 through further start/redirect pulses until rst_n.
- Async reset mid-stream: assert rst_n low between edges → all outputs at reset values immediately; after release and start, the first if_pc = RESET_PC.

Source files
------------

// File: rtl/tpi_pkg.sv
// Shared types and constants for the TPI core front end.
// No logic; pure declarations.
// No handshake; imported by fetch and core-level modules.
package tpi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } fetch_state_t;

    // Canonical RISC-V NOP (addi x0, x0, 0), used by decode for bubbles.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives IM word address, holds PC, presents if_instr/if_pc to decode.
// Latency: IM is combinational, one instruction registered per cycle; a redirect costs one bubble.
// Backpressure: fetch register and pc hold while if_valid && !id_ready; redirects override it.
module fetch_ctrl
    import tpi_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned ROM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] im_addr,
    input  logic [31:0] im_instr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        busy,
    output logic        done,
    output logic        err_misaligned,
    output logic [15:0] instr_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [15:0]  instr_count_q, instr_count_d;
    logic         err_q, err_d;

    logic adv;
    logic handshake;
    logic in_image;

    assign adv       = !if_valid_q || id_ready;
    assign handshake = if_valid_q && id_ready;
    // Only the word index matters; the upper bits take part so wrapped or far PCs count as outside the image.
    assign in_image  = ({2'b00, pc_q[31:2]} < ROM_DEPTH);

    // State register and fetch pipeline register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'h0;
            if_pc_q       <= 32'h0;
            instr_count_q <= 16'h0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            instr_count_q <= instr_count_d;
            err_q         <= err_d;
        end
    end

    // Next-state: redirect beats advance; a handshake in the redirect cycle is still counted.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        err_d         = err_q;
        instr_count_d = instr_count_q;

        if (handshake && (instr_count_q != 16'hFFFF)) begin
            instr_count_d = instr_count_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN, DONE: begin
                if (redir_valid) begin
                    if_valid_d = 1'b0;
                    if (redir_pc[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else begin
                        pc_d    = redir_pc;
                        state_d = RUN;
                    end
                end else if ((state_q == RUN) && adv) begin
                    if (in_image) begin
                        if_instr_d = im_instr;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end else begin
                        if_valid_d = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            ERROR: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign im_addr        = pc_q[17:2];
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign instr_count    = instr_count_q;
    assign err_misaligned = err_q;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE) && !if_valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl against a behavioural fetch model.
// Latency: model advanced once per rising edge, outputs compared on the falling edge.
// Backpressure: id_ready driven directed then randomly.
module tb_fetch_ctrl;

    localparam int DEPTH = 28;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] im_addr;
    logic [31:0] im_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        busy;
    logic        done;
    logic        err_misaligned;
    logic [15:0] instr_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom [64];

    // Reference model state
    int          m_st;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [15:0] m_cnt;
    logic        m_err;

    fetch_ctrl #(.RESET_PC(32'h0), .ROM_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .im_addr        (im_addr),
        .im_instr       (im_instr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .busy           (busy),
        .done           (done),
        .err_misaligned (err_misaligned),
        .instr_count    (instr_count)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory beside the sequencer.
    always_comb begin
        if (im_addr < 16'd64) im_instr = rom[im_addr[5:0]];
        else                  im_instr = {16'hBAD0, im_addr};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = M_IDLE;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_cnt   = 16'h0;
        m_err   = 1'b0;
    endtask

    // One clock edge of fetch behaviour, taken from the rules with plain arithmetic.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_valid && id_ready && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_st == M_IDLE) begin
            if (start) m_st = M_RUN;
        end else if (m_st == M_RUN || m_st == M_DONE) begin
            if (redir_valid) begin
                m_valid = 1'b0;
                if (redir_pc % 4 != 0) begin
                    m_err = 1'b1;
                    m_st  = M_ERR;
                end else begin
                    m_pc = redir_pc;
                    m_st = M_RUN;
                end
            end else if (m_st == M_RUN && (!m_valid || id_ready)) begin
                if ((m_pc / 4) < DEPTH) begin
                    m_instr = rom[m_pc / 4];
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                end else begin
                    m_valid = 1'b0;
                    m_st    = M_DONE;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("if_valid",    32'(if_valid),       32'(m_valid));
        chk("if_instr",    if_instr,            m_instr);
        chk("if_pc",       if_pc,               m_ipc);
        chk("im_addr",     32'(im_addr),        32'(m_pc[17:2]));
        chk("busy",        32'(busy),           32'(m_st == M_RUN));
        chk("done",        32'(done),           32'(m_st == M_DONE && !m_valid));
        chk("err",         32'(err_misaligned), 32'(m_err));
        chk("instr_count", 32'(instr_count),    32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] last_pc;
    int          r;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h0000_0293;
        rom[1] = 32'h0000_0393;
        rom[2] = 32'h0010_0313;
        rom[4] = 32'h0005_ae03;
        rom[8] = 32'h01c0_0fb3;

        rst_n = 1'b0; start = 1'b0; id_ready = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
        model_reset();
        #1 check_all();

        // Reset/start and streaming
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; id_ready = 1'b1;
        step();
        chk("start_busy", 32'(busy), 32'h1);
        start = 1'b0;
        step();
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instr, 32'h0000_0293);
        step();
        chk("second_pc", if_pc, 32'h4);
        chk("second_instr", if_instr, 32'h0000_0393);
        step();
        chk("third_pc", if_pc, 32'h8);
        chk("third_instr", if_instr, 32'h0010_0313);
        step();
        chk("count_after3", 32'(instr_count), 32'h3);
        step();
        chk("bp_pc", if_pc, 32'h10);

        // Backpressure
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_pc", if_pc, 32'h10);
            chk("bp_hold_instr", if_instr, 32'h0005_ae03);
            chk("bp_hold_addr", 32'(im_addr), 32'h5);
            chk("bp_hold_cnt", 32'(instr_count), 32'h4);
        end
        id_ready = 1'b1;
        step();
        chk("bp_resume_pc", if_pc, 32'h14);

        // Redirect while stalled
        id_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'h20;
        step();
        chk("redir_bubble", 32'(if_valid), 32'h0);
        redir_valid = 1'b0; id_ready = 1'b1;
        step();
        chk("redir_valid", 32'(if_valid), 32'h1);
        chk("redir_pc", if_pc, 32'h20);
        chk("redir_instr", if_instr, 32'h01c0_0fb3);

        // End of image
        redir_valid = 1'b1; redir_pc = 32'h60;
        step();
        redir_valid = 1'b0;
        last_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if_valid) last_pc = if_pc;
            else if (done) break;
        end
        chk("eoi_last_pc", last_pc, 32'h6C);
        chk("eoi_done", 32'(done), 32'h1);
        redir_valid = 1'b1; redir_pc = 32'h20;
        step();
        chk("eoi_restart_busy", 32'(busy), 32'h1);
        redir_valid = 1'b0;
        step();
        chk("eoi_restart_pc", if_pc, 32'h20);

        // Misaligned redirect is sticky
        redir_valid = 1'b1; redir_pc = 32'h22;
        step();
        chk("mis_err", 32'(err_misaligned), 32'h1);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; redir_pc = 32'h20; redir_valid = 1'(i % 2);
            step();
            chk("mis_stuck_valid", 32'(if_valid), 32'h0);
            chk("mis_stuck_err", 32'(err_misaligned), 32'h1);
        end
        start = 1'b0; redir_valid = 1'b0;

        // Async reset mid-stream and restart
        async_reset();
        chk("arst_count", 32'(instr_count), 32'h0);
        start = 1'b1; id_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("arst_first_pc", if_pc, 32'h0);
        chk("arst_first_valid", 32'(if_valid), 32'h1);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            start       = ($urandom_range(0, 7) == 0);
            id_ready    = ($urandom_range(0, 9) < 7);
            redir_valid = ($urandom_range(0, 11) == 0);
            r = int'($urandom_range(0, 99));
            if (r < 3)       redir_pc = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            else if (r < 10) redir_pc = ($urandom | 32'h4000_0000) & 32'hFFFF_FFFC;
            else             redir_pc = 32'($urandom_range(0, 31)) << 2;
            if ($urandom_range(0, 149) == 0) async_reset();
            else                             step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
